// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared constants and helpers for the convolution filter datapath.
//   PIX_W        : default pixel width in bits
//   PACK_DEFAULT : default number of pixels per packed output beat
//   keep_mask()  : contiguous lane mask covering lanes 0..lane inclusive
// -----------------------------------------------------------------------------
package filter_pkg;

  localparam int PIX_W        = 8;
  localparam int PACK_DEFAULT = 4;

  // Returns a 32-bit mask with bits [lane:0] set. Callers size-cast the
  // result down to their own lane count.
  function automatic logic [31:0] keep_mask(input int unsigned lane);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i <= lane);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_pixel_packer_if.sv
// -----------------------------------------------------------------------------
// Stream interfaces used by axis_pixel_packer.
//   pix_stream_if  : pixel stream from the output pixel FIFO
//                    s_valid/s_ready handshake, s_data pixel,
//                    i_EOL end-of-line flag, i_tlast end-of-frame flag.
//                    master = FIFO side, slave = consumer side.
//   axis_stream_if : packed AXI4-Stream beat
//                    m_axis_tvalid/m_axis_tready handshake, m_axis_tdata,
//                    m_axis_tkeep lane mask, m_axis_tuser line end,
//                    m_axis_tlast frame end.
//                    master = beat producer, slave = downstream sink.
// -----------------------------------------------------------------------------
interface pix_stream_if #(
  parameter int DATA_WIDTH = filter_pkg::PIX_W
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  i_EOL;
  logic                  i_tlast;

  modport master (output s_valid, s_data, i_EOL, i_tlast, input s_ready);
  modport slave  (input s_valid, s_data, i_EOL, i_tlast, output s_ready);
endinterface

interface axis_stream_if #(
  parameter int DATA_WIDTH = filter_pkg::PIX_W,
  parameter int PACK       = filter_pkg::PACK_DEFAULT
);
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic [DATA_WIDTH*PACK-1:0] m_axis_tdata;
  logic [PACK-1:0]            m_axis_tkeep;
  logic                       m_axis_tuser;
  logic                       m_axis_tlast;

  modport master (output m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
                  m_axis_tuser, m_axis_tlast, input m_axis_tready);
  modport slave  (input m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
                  m_axis_tuser, m_axis_tlast, output m_axis_tready);
endinterface

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Single-entry holding register for a valid/ready stream stage.
// ready_o = ~tvalid_o | tready_i, so a new beat may be loaded whenever the
// slot is empty or is being drained in this same cycle. The load has priority
// over the drain, which lets back-to-back beats flow at one per cycle.
// The caller must only assert load_i while ready_o is high.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load_i               capture tdata_i/tkeep_i/tuser_i/tlast_i this cycle
//   tdata_i..tlast_i     beat to capture
//   ready_o              slot can accept a load this cycle
//   tvalid_o..tlast_o    registered beat towards the sink
//   tready_i             sink accepts the current beat
// -----------------------------------------------------------------------------
module axis_out_reg #(
  parameter int TDATA_W = 32,
  parameter int TKEEP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [TDATA_W-1:0] tdata_i,
  input  logic [TKEEP_W-1:0] tkeep_i,
  input  logic               tuser_i,
  input  logic               tlast_i,
  output logic               ready_o,
  output logic               tvalid_o,
  output logic [TDATA_W-1:0] tdata_o,
  output logic [TKEEP_W-1:0] tkeep_o,
  output logic               tuser_o,
  output logic               tlast_o,
  input  logic               tready_i
);

  logic               valid_q;
  logic [TDATA_W-1:0] data_q;
  logic [TKEEP_W-1:0] keep_q;
  logic               user_q;
  logic               last_q;

  // Depends only on registered state and the sink, never on the upstream
  // valid or data, so no combinational valid->ready loop can form.
  assign ready_o = ~valid_q | tready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= tdata_i;
      keep_q  <= tkeep_i;
      user_q  <= tuser_i;
      last_q  <= tlast_i;
    end else if (tready_i) begin
      // Drained with no replacement: the slot empties. Payload is left as is;
      // it is not observable while valid is low.
      valid_q <= 1'b0;
    end
  end

  assign tvalid_o = valid_q;
  assign tdata_o  = data_q;
  assign tkeep_o  = keep_q;
  assign tuser_o  = user_q;
  assign tlast_o  = last_q;

endmodule

// File: rtl/axis_pixel_packer.sv
// -----------------------------------------------------------------------------
// axis_pixel_packer
// Packs PACK pixels of DATA_WIDTH bits into one wide AXI4-Stream beat.
// Lane 0 holds the earliest pixel in bits [DATA_WIDTH-1:0]. A beat closes when
// its last lane fills, or early on an end-of-line or end-of-frame pixel; a
// partial beat carries a contiguous tkeep from lane 0. tuser marks a beat that
// ends a line (EOL or frame end), tlast marks the frame end.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pix            pix_stream_if.slave  : pixels from the output pixel FIFO
//   axis           axis_stream_if.master: packed beats to downstream
//   o_beat_cnt     (AXIS_PIXEL_PACKER_CNT_EN only) beats accepted, mod 2^32
//   o_frame_cnt    (AXIS_PIXEL_PACKER_CNT_EN only) tlast beats accepted,
//                  mod 2^16
//
// Build option: define AXIS_PIXEL_PACKER_CNT_EN to add the beat/frame counters.
// -----------------------------------------------------------------------------
module axis_pixel_packer
  import filter_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int PACK       = PACK_DEFAULT,
  parameter int PACK_LOG2  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  pix_stream_if.slave  pix,
  axis_stream_if.master axis
`ifdef AXIS_PIXEL_PACKER_CNT_EN
  ,
  output logic [31:0]  o_beat_cnt,
  output logic [15:0]  o_frame_cnt
`endif
);

  localparam int BEAT_W = DATA_WIDTH * PACK;

  // Accumulator for the beat under construction.
  logic [PACK_LOG2-1:0] lane_q, lane_d;
  logic [BEAT_W-1:0]    acc_data_q, acc_data_d;
  logic [PACK-1:0]      acc_keep_q, acc_keep_d;

  logic              out_ready;
  logic              in_hs;
  logic              close;
  logic [PACK-1:0]   lane_bit;
  logic [PACK-1:0]   beat_keep;
  logic [BEAT_W-1:0] beat_data;

  logic              out_tvalid;
  logic              out_tlast;

  assign pix.s_ready = out_ready;
  assign in_hs       = pix.s_valid & out_ready;

  // The last lane always closes, so the lane counter only wraps through close.
  assign close = (lane_q == PACK_LOG2'(PACK - 1)) | pix.i_EOL | pix.i_tlast;

  assign lane_bit  = PACK'(1) << lane_q;
  assign beat_keep = PACK'(keep_mask(32'(lane_q)));

  // Accumulator with the incoming pixel merged into the current lane; lanes
  // beyond the current one are forced to zero for a partial beat.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    beat_data = acc_data_q;
    beat_data[lane_q*DATA_WIDTH +: DATA_WIDTH] = pix.s_data;
    for (int i = 0; i < PACK; i++) begin
      if (!beat_keep[i]) begin
        beat_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  always_comb begin
    lane_d     = lane_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    if (in_hs) begin
      if (close) begin
        lane_d     = '0;
        acc_data_d = '0;
        acc_keep_d = '0;
      end else begin
        lane_d     = lane_q + 1'b1;
        acc_data_d = beat_data;
        acc_keep_d = acc_keep_q | lane_bit;
      end
    end
  end

  // Reset discards any partially packed beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
    end else begin
      lane_q     <= lane_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
    end
  end

  axis_out_reg #(
    .TDATA_W (BEAT_W),
    .TKEEP_W (PACK)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (in_hs & close),
    .tdata_i  (beat_data),
    .tkeep_i  (beat_keep),
    .tuser_i  (pix.i_EOL | pix.i_tlast),
    .tlast_i  (pix.i_tlast),
    .ready_o  (out_ready),
    .tvalid_o (out_tvalid),
    .tdata_o  (axis.m_axis_tdata),
    .tkeep_o  (axis.m_axis_tkeep),
    .tuser_o  (axis.m_axis_tuser),
    .tlast_o  (out_tlast),
    .tready_i (axis.m_axis_tready)
  );

  assign axis.m_axis_tvalid = out_tvalid;
  assign axis.m_axis_tlast  = out_tlast;

`ifdef AXIS_PIXEL_PACKER_CNT_EN
  logic        out_hs;
  logic [31:0] beat_cnt_q;
  logic [15:0] frame_cnt_q;

  assign out_hs = out_tvalid & axis.m_axis_tready;

  // Free-running statistics; both wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (out_hs) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (out_tlast) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign o_beat_cnt  = beat_cnt_q;
  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule
